// File: rtl/sysid_check_pkg.sv
// sysid_check_pkg: shared types and constants for the sysid checker.
// FSM state enum, slave word addresses, default expected words.
package sysid_check_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      WAIT_ID,
      RD_TS,
      WAIT_TS,
      CHECK,
      DONE
   } sysid_state_t;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   localparam logic [31:0] SYSID_EXPECTED_ID = 32'hACD51302;
   localparam logic [31:0] SYSID_EXPECTED_TS = 32'h53104B65;

   // Width of a counter that must hold n-1 (counters run n-1 .. 0).
   function automatic int ctr_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sysid_down_ctr.sv
// sysid_down_ctr: loadable down-counter, saturates at 0.
// Ports: clock, reset, load/load_value, dec, zero (count == 0).
module sysid_down_ctr
   import sysid_check_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         zero
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_value;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - ONE;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: Avalon-MM master that reads sysid ID (addr 0) and
// timestamp (addr 1) and compares them with build-time values.
// Ports: clock, reset (async, high), start pulse; avm_address/avm_read
// out, avm_waitrequest/avm_readdata/avm_readdatavalid in; status out:
// busy, done pulse, sticky pass/fail/timeout_err, id_value, ts_value,
// retry_count.
// Option macro SYSID_CHECK_RECHECK_EN: rerun RECHECK_PERIOD cycles
// after each completed check.
module sysid_check_ctrl
   import sysid_check_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS,
   parameter int          CHECK_TS       = 1,
   parameter int          AUTO_START     = 1,
   parameter int          TIMEOUT_CYCLES = 256,
   parameter int          MAX_RETRIES    = 3
`ifdef SYSID_CHECK_RECHECK_EN
   ,
   parameter int          RECHECK_PERIOD = 1000000
`endif
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout_err,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic [1:0]  retry_count
);

   localparam int TW = ctr_width(TIMEOUT_CYCLES);
   // Loaded with N-1 so zero marks the N-th cycle of the read.
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRIES);

   sysid_state_t state_q, state_d;

   logic        in_rd, in_wait;
   logic        accept, got;
   logic        tmo_zero, tmo_ev, tmo_load;
   logic        retry_ok, launch, rerun, match;
   logic        auto_q, done_q;
   logic        pass_q, fail_q, tmo_q;
   logic [1:0]  retry_q;
   logic [31:0] id_q, ts_q;

   assign in_rd   = (state_q == RD_ID) || (state_q == RD_TS);
   assign in_wait = (state_q == WAIT_ID) || (state_q == WAIT_TS);
   assign accept  = in_rd && !avm_waitrequest;
   // Zero-latency data in the accept cycle counts as well.
   assign got     = avm_readdatavalid && (in_wait || accept);
   // Data on the expiry cycle wins over the timeout.
   assign tmo_ev  = (in_rd || in_wait) && tmo_zero && !got;
   assign retry_ok = retry_q < RETRY_MAX;

   assign launch =
      ((state_q == IDLE) && (start || auto_q)) ||
      ((state_q == DONE) && (start || rerun));

   assign match = (id_q == EXPECTED_ID) &&
                  ((CHECK_TS == 0) || (ts_q == EXPECTED_TS));

   assign tmo_load = tmo_ev ||
      (((state_d == RD_ID) || (state_d == RD_TS)) &&
       (state_d != state_q));

   sysid_down_ctr #(
      .W(TW)
   ) u_tmo (
      .clock      (clock),
      .reset      (reset),
      .load       (tmo_load),
      .load_value (TMO_LOAD),
      .dec        (in_rd || in_wait),
      .zero       (tmo_zero)
   );

`ifdef SYSID_CHECK_RECHECK_EN
   localparam int RW = ctr_width(RECHECK_PERIOD);
   localparam logic [RW-1:0] RC_LOAD = RW'(RECHECK_PERIOD - 1);

   logic rc_zero;

   sysid_down_ctr #(
      .W(RW)
   ) u_recheck (
      .clock      (clock),
      .reset      (reset),
      .load       ((state_d == DONE) && (state_q != DONE)),
      .load_value (RC_LOAD),
      .dec        (state_q == DONE),
      .zero       (rc_zero)
   );

   // A start in DONE leaves DONE first, so the timer is abandoned.
   assign rerun = rc_zero && (state_q == DONE);
`else
   assign rerun = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:
            if (launch) state_d = RD_ID;
         RD_ID:
            if (got) state_d = RD_TS;
            else if (tmo_ev) state_d = retry_ok ? RD_ID : DONE;
            else if (accept) state_d = WAIT_ID;
         WAIT_ID:
            if (got) state_d = RD_TS;
            else if (tmo_ev) state_d = retry_ok ? RD_ID : DONE;
         RD_TS:
            if (got) state_d = CHECK;
            else if (tmo_ev) state_d = retry_ok ? RD_ID : DONE;
            else if (accept) state_d = WAIT_TS;
         WAIT_TS:
            if (got) state_d = CHECK;
            else if (tmo_ev) state_d = retry_ok ? RD_ID : DONE;
         CHECK:
            state_d = DONE;
         DONE:
            if (launch) state_d = RD_ID;
         default:
            state_d = IDLE;
      endcase
   end

   always_comb begin
      avm_read    = 1'b0;
      avm_address = SYSID_ADDR_ID;
      busy        = 1'b0;
      unique case (state_q)
         RD_ID: begin
            avm_read = 1'b1;
            busy     = 1'b1;
         end
         RD_TS: begin
            avm_read    = 1'b1;
            avm_address = SYSID_ADDR_TS;
            busy        = 1'b1;
         end
         WAIT_ID, WAIT_TS, CHECK:
            busy = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         auto_q  <= (AUTO_START != 0);
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         tmo_q   <= 1'b0;
         retry_q <= 2'd0;
         id_q    <= '0;
         ts_q    <= '0;
      end else begin
         auto_q <= 1'b0;
         done_q <= (state_d == DONE) && (state_q != DONE);
         if (launch) begin
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tmo_q   <= 1'b0;
            retry_q <= 2'd0;
         end
         if (tmo_ev) begin
            if (retry_ok) begin
               retry_q <= retry_q + 2'd1;
            end else begin
               fail_q <= 1'b1;
               tmo_q  <= 1'b1;
            end
         end
         if (state_q == CHECK) begin
            pass_q <= match;
            fail_q <= !match;
         end
         if (got && ((state_q == RD_ID) || (state_q == WAIT_ID))) begin
            id_q <= avm_readdata;
         end
         if (got && ((state_q == RD_TS) || (state_q == WAIT_TS))) begin
            ts_q <= avm_readdata;
         end
      end
   end

   assign done        = done_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign timeout_err = tmo_q;
   assign retry_count = retry_q;
   assign id_value    = id_q;
   assign ts_value    = ts_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb_sysid_check_ctrl: directed bench for sysid_check_ctrl.
// Instance a: defaults, TIMEOUT_CYCLES=16; instance b: CHECK_TS=0.
module tb_sysid_check_ctrl;
   import sysid_check_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  start, wr, rdv;
   logic [1:0]  rd, addr, busy, done, pass, fail, tmo;
   logic [31:0] rdata [2];
   logic [31:0] id [2];
   logic [31:0] ts [2];
   logic [1:0]  rc [2];

   int vectors = 0;
   int miscompares = 0;
   int acc [2] = '{0, 0};
   int cyc = 0;
   int t0, a0, n;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++)
         if (rd[i] && !wr[i]) acc[i]++;
   end

   sysid_check_ctrl #(
      .TIMEOUT_CYCLES(16)
   ) u_dut_a (
      .clock             (clk),
      .reset             (rst),
      .start             (start[0]),
      .avm_address       (addr[0]),
      .avm_read          (rd[0]),
      .avm_waitrequest   (wr[0]),
      .avm_readdata      (rdata[0]),
      .avm_readdatavalid (rdv[0]),
      .busy              (busy[0]),
      .done              (done[0]),
      .pass              (pass[0]),
      .fail              (fail[0]),
      .timeout_err       (tmo[0]),
      .id_value          (id[0]),
      .ts_value          (ts[0]),
      .retry_count       (rc[0])
   );

   sysid_check_ctrl #(
      .CHECK_TS       (0),
      .AUTO_START     (0),
      .TIMEOUT_CYCLES (16)
`ifdef SYSID_CHECK_RECHECK_EN
      ,
      .RECHECK_PERIOD (100)
`endif
   ) u_dut_b (
      .clock             (clk),
      .reset             (rst),
      .start             (start[1]),
      .avm_address       (addr[1]),
      .avm_read          (rd[1]),
      .avm_waitrequest   (wr[1]),
      .avm_readdata      (rdata[1]),
      .avm_readdatavalid (rdv[1]),
      .busy              (busy[1]),
      .done              (done[1]),
      .pass              (pass[1]),
      .fail              (fail[1]),
      .timeout_err       (tmo[1]),
      .id_value          (id[1]),
      .ts_value          (ts[1]),
      .retry_count       (rc[1])
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %08h expected %08h",
                tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input int s);
      start[s] = 1'b1;
      @(negedge clk);
      start[s] = 1'b0;
   endtask

   // Slave model: ws stall cycles, then data lat cycles after accept.
   task automatic serve(input int s, input int ws, input int lat,
                        input logic [31:0] data, input logic a_exp);
      int   k = 0;
      logic stable = 1'b1;
      while (!rd[s] && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("read_strobe", 32'(rd[s]), 32'd1);
      chk("read_addr", 32'(addr[s]), 32'(a_exp));
      wr[s] = (ws > 0);
      for (int i = 0; i < ws; i++) begin
         @(negedge clk);
         if (rd[s] !== 1'b1 || addr[s] !== a_exp) stable = 1'b0;
      end
      chk("stall_stable", 32'(stable), 32'd1);
      wr[s] = 1'b0;
      for (int i = 0; i < lat; i++) @(negedge clk);
      rdv[s]   = 1'b1;
      rdata[s] = data;
      @(negedge clk);
      rdv[s]   = 1'b0;
      rdata[s] = '0;
   endtask

   task automatic wait_done(input int s, input int max);
      int m = 0;
      do begin
         @(negedge clk);
         m++;
      end while (!done[s] && m < max);
      chk("done_seen", 32'(done[s]), 32'd1);
   endtask

   initial begin
      rst      = 1'b1;
      start    = '0;
      wr       = '0;
      rdv      = '0;
      rdata[0] = '0;
      rdata[1] = '0;
      repeat (3) @(negedge clk);
      chk("rst_read", 32'(rd[0]), 32'd0);
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_done", 32'(done[0]), 32'd0);
      chk("rst_pass", 32'(pass[0]), 32'd0);
      chk("rst_fail", 32'(fail[0]), 32'd0);
      chk("rst_id", id[0], 32'd0);
      chk("rst_retry", 32'(rc[0]), 32'd0);

      // 1: auto start, clean pass
      rst = 1'b0;
      t0  = cyc;
      serve(0, 0, 1, SYSID_EXPECTED_ID, SYSID_ADDR_ID);
      serve(0, 0, 1, SYSID_EXPECTED_TS, SYSID_ADDR_TS);
      wait_done(0, 20);
      chk("t1_latency", 32'((cyc - t0) <= 8), 32'd1);
      chk("t1_pass", 32'(pass[0]), 32'd1);
      chk("t1_fail", 32'(fail[0]), 32'd0);
      chk("t1_id", id[0], 32'hACD51302);
      chk("t1_ts", ts[0], 32'h53104B65);
      chk("t1_busy", 32'(busy[0]), 32'd0);
      chk("b_idle_busy", 32'(busy[1]), 32'd0);
      chk("b_idle_read", 32'(rd[1]), 32'd0);
      @(negedge clk);
      chk("t1_done_1cyc", 32'(done[0]), 32'd0);
      chk("t1_pass_hold", 32'(pass[0]), 32'd1);

      // 2: ID mismatch
      pulse_start(0);
      chk("t2_busy", 32'(busy[0]), 32'd1);
      chk("t2_pass_clr", 32'(pass[0]), 32'd0);
      serve(0, 0, 1, 32'h0, SYSID_ADDR_ID);
      serve(0, 0, 1, SYSID_EXPECTED_TS, SYSID_ADDR_TS);
      wait_done(0, 20);
      chk("t2_fail", 32'(fail[0]), 32'd1);
      chk("t2_pass", 32'(pass[0]), 32'd0);
      chk("t2_tmo", 32'(tmo[0]), 32'd0);
      chk("t2_retry", 32'(rc[0]), 32'd0);
      chk("t2_id", id[0], 32'd0);

      // 4: 10-cycle waitrequest on both reads
      @(negedge clk);
      a0 = acc[0];
      pulse_start(0);
      serve(0, 10, 1, SYSID_EXPECTED_ID, SYSID_ADDR_ID);
      serve(0, 10, 2, SYSID_EXPECTED_TS, SYSID_ADDR_TS);
      wait_done(0, 20);
      chk("t4_accepts", 32'(acc[0] - a0), 32'd2);
      chk("t4_pass", 32'(pass[0]), 32'd1);
      chk("t4_retry", 32'(rc[0]), 32'd0);

      // data on the last allowed cycle beats the timeout
      @(negedge clk);
      pulse_start(0);
      serve(0, 0, 15, SYSID_EXPECTED_ID, SYSID_ADDR_ID);
      serve(0, 0, 1, SYSID_EXPECTED_TS, SYSID_ADDR_TS);
      wait_done(0, 20);
      chk("edge_retry", 32'(rc[0]), 32'd0);
      chk("edge_pass", 32'(pass[0]), 32'd1);

      // 3: no readdatavalid; start while busy ignored
      @(negedge clk);
      a0 = acc[0];
      t0 = cyc;
      pulse_start(0);
      repeat (20) @(negedge clk);
      pulse_start(0);
      wait_done(0, 200);
      chk("t3_cycles", 32'(cyc - t0), 32'd65);
      chk("t3_strobes", 32'(acc[0] - a0), 32'd4);
      chk("t3_fail", 32'(fail[0]), 32'd1);
      chk("t3_tmo", 32'(tmo[0]), 32'd1);
      chk("t3_retry", 32'(rc[0]), 32'd3);
      chk("t3_pass", 32'(pass[0]), 32'd0);

      // 5: reset in WAIT_TS, then in a stalled RD_ID
      @(negedge clk);
      pulse_start(0);
      serve(0, 0, 1, SYSID_EXPECTED_ID, SYSID_ADDR_ID);
      @(negedge clk);
      chk("t5_in_wait", 32'(busy[0]), 32'd1);
      rst = 1'b1;
      #1;
      chk("t5_busy", 32'(busy[0]), 32'd0);
      chk("t5_read", 32'(rd[0]), 32'd0);
      chk("t5_id", id[0], 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wr[0] = 1'b1;
      chk("t5_rd_hold", 32'(rd[0]), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t5_read_async", 32'(rd[0]), 32'd0);
      wr[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      serve(0, 0, 1, SYSID_EXPECTED_ID, SYSID_ADDR_ID);
      serve(0, 0, 1, SYSID_EXPECTED_TS, SYSID_ADDR_TS);
      wait_done(0, 20);
      chk("t5_pass", 32'(pass[0]), 32'd1);
      chk("t5_fail", 32'(fail[0]), 32'd0);

      // 6: CHECK_TS=0 ignores a timestamp mismatch
      pulse_start(1);
      serve(1, 0, 1, SYSID_EXPECTED_ID, SYSID_ADDR_ID);
      serve(1, 0, 1, 32'h12345678, SYSID_ADDR_TS);
      wait_done(1, 20);
      chk("t6_pass", 32'(pass[1]), 32'd1);
      chk("t6_fail", 32'(fail[1]), 32'd0);
      chk("t6_ts", ts[1], 32'h12345678);
`ifdef SYSID_CHECK_RECHECK_EN
      n = 0;
      while (!rd[1] && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("t6_recheck", 32'(n), 32'd100);
`else
      repeat (150) @(negedge clk);
      chk("t6_hold_busy", 32'(busy[1]), 32'd0);
      chk("t6_hold_read", 32'(rd[1]), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
